// File: rtl/snake_pad_reader.sv
// snake_pad_reader: polls an NES (default) or SNES pad (define SNAKE_PAD_SNES_EN) and decodes snake direction.
// One read = latch pulse, then N shift clocks; buttons/dir update with a one-cycle valid.
module snake_pad_reader #(
    parameter int TICK_DIV = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [11:0] buttons,
    output logic        valid,
    output logic        busy,
    output logic [1:0]  dir
);
    localparam int HALF = TICK_DIV / 2;
    localparam int CW = $clog2(TICK_DIV + 1);
`ifdef SNAKE_PAD_SNES_EN
    localparam int N = 12;
`else
    localparam int N = 8;
`endif
    localparam int IW = $clog2(N);
    localparam logic [2:0] IDLE = 3'd0, LATCH = 3'd1, HIGH = 3'd2, LOW = 3'd3, DONE = 3'd4;

    logic [2:0]    r_state, w_next;
    logic [CW-1:0] r_cnt, w_load;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_shadow;
    logic [11:0]   r_buttons;
    logic [1:0]    r_dir, w_dir;
    logic          r_pad_latch, r_pad_clk, r_valid, r_busy, w_tick;

    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign buttons   = r_buttons;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign dir       = r_dir;

    always_comb begin
        w_tick = r_cnt == '0;
        w_next = r_state == IDLE  ? (poll ? LATCH : IDLE) :
                 r_state == LATCH ? (w_tick ? HIGH : LATCH) :
                 r_state == HIGH  ? (w_tick ? (r_idx == IW'(N - 1) ? DONE : LOW) : HIGH) :
                 r_state == LOW   ? (w_tick ? HIGH : LOW) : IDLE;
        w_load = w_next == LATCH ? CW'(TICK_DIV - 1) :
                 (w_next == HIGH || w_next == LOW) ? CW'(HALF - 1) : '0;
        // Priority up > down > left > right on the standard d-pad bit positions
        w_dir  = r_shadow[4] ? 2'b00 : r_shadow[5] ? 2'b01 : r_shadow[6] ? 2'b10 : 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_buttons   <= '0;
            r_dir       <= 2'b11;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_next != r_state ? w_load : (w_tick ? r_cnt : r_cnt - 1'b1);
            r_pad_latch <= w_next == LATCH;
            r_pad_clk   <= w_next != LOW;
            r_valid     <= r_state == DONE;
            r_busy      <= (r_state == IDLE && poll) || (r_busy && !r_valid);
            if (r_state == LATCH)
                r_idx <= '0;
            else if (r_state == LOW && w_tick)
                r_idx <= r_idx + 1'b1;
            if (r_state == HIGH && w_tick)
                r_shadow[r_idx] <= ~pad_data;
            if (r_state == DONE) begin
                r_buttons <= 12'(r_shadow);
                if (|r_shadow[7:4])
                    r_dir <= w_dir;
            end
        end
    end
endmodule

// File: tb/tb_snake_pad_reader.sv
// tb_snake_pad_reader: scoreboard bench for snake_pad_reader with a synchronous pad shift-register model.
module tb_snake_pad_reader;
    localparam int TICK_DIV = 300;
    localparam int HALF = TICK_DIV / 2;
`ifdef SNAKE_PAD_SNES_EN
    localparam int N = 12;
`else
    localparam int N = 8;
`endif
    localparam int LAT = TICK_DIV + (2 * N - 1) * HALF + 1;

    typedef struct {
        logic [11:0] b;
        logic [1:0]  d;
        int          t0;
    } exp_t;

    logic        clk = 1'b0, rst_n, poll, pad_data, pad_latch, pad_clk, valid, busy;
    logic [11:0] buttons;
    logic [1:0]  dir, exp_dir;
    logic [15:0] sr, pat;
    logic        clk_d;
    logic [11:0] mask;
    int          cyc = 0, n_chk = 0, n_err = 0, n_valid = 0, lat = 0, lows = 0, ovl = 0;
    logic        prev_clk = 1'b1;
    exp_t        q[$];
    exp_t        e;

    snake_pad_reader #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .poll(poll), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
        .valid(valid), .busy(busy), .dir(dir)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: parallel load on latch, shift one bit after each pad_clk rise
    assign pad_data = ~sr[0];
    always @(posedge clk) begin
        if (pad_latch)
            sr <= pat;
        else if (pad_clk && !clk_d)
            sr <= sr >> 1;
        clk_d <= pad_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || (poll && !busy)) begin
            lat  <= 0;
            lows <= 0;
            ovl  <= 0;
        end else begin
            if (pad_latch) lat <= lat + 1;
            if (prev_clk && !pad_clk) lows <= lows + 1;
            if (pad_latch && !pad_clk) ovl <= ovl + 1;
        end
        prev_clk <= pad_clk;
        if (valid) begin
            n_valid <= n_valid + 1;
            if (q.size() == 0)
                chk("spurious_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("buttons", 32'(buttons), 32'(e.b));
                chk("dir", 32'(dir), 32'(e.d));
                chk("latency", cyc - e.t0, LAT);
                chk("latch_cycles", lat, TICK_DIV);
                chk("clk_low_pulses", lows, N - 1);
                chk("latch_clk_overlap", ovl, 0);
            end
        end
    end

    task automatic start(input logic [11:0] p);
        logic [11:0] eb;
        eb = p & mask;
        pat = {4'b0, p};
        exp_dir = eb[4] ? 2'b00 : eb[5] ? 2'b01 : eb[6] ? 2'b10 : eb[7] ? 2'b11 : exp_dir;
        q.push_back('{eb, exp_dir, cyc + 1});
        poll = 1'b1;
        @(posedge clk);
        #1 poll = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2 * LAT && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int nv;
        mask = 12'((1 << N) - 1);
        exp_dir = 2'b11;
        rst_n = 1'b0;
        poll = 1'b0;
        pat = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_latch", 32'(pad_latch), 0);
        chk("idle_clk", 32'(pad_clk), 1);
        chk("idle_buttons", 32'(buttons), 0);
        chk("idle_dir", 32'(dir), 3);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valids", n_valid, 0);

        start(12'h010); wait_done();
        start(12'h1C0); wait_done();

        nv = n_valid;
        start(12'h000);
        repeat (10) @(posedge clk);
        #1 chk("busy_during_read", 32'(busy), 1);
        poll = 1'b1;
        @(posedge clk);
        #1 poll = 1'b0;
        wait_done();
        chk("one_valid", n_valid - nv, 1);
        chk("busy_after", 32'(busy), 0);

        start(12'h020); wait_done();
        start(12'h080); wait_done();
        start(12'hFFF); wait_done();

        start(12'h0FF);
        repeat (1000) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        exp_dir = 2'b11;
        #1;
        chk("rst_buttons", 32'(buttons), 0);
        chk("rst_dir", 32'(dir), 3);
        chk("rst_latch", 32'(pad_latch), 0);
        chk("rst_clk", 32'(pad_clk), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 start(12'h040);
        repeat (1000) @(posedge clk);
        #1 chk("buttons_hold_after_rst", 32'(buttons), 0);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
